// File: rtl/apb_slave_mem_responder.sv
// apb_slave_mem_responder: APB4 completer with a word memory window, programmable wait states and error response
module apb_slave_mem_responder #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int NO_OF_SLAVES      = 16,
  parameter int SLAVE_ID          = 0,
  parameter int SLAVE_MEMORY_SIZE = 12,
  parameter int SLAVE_MEMORY_GAP  = 2,
  parameter int PRIV_ONLY         = 0
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NO_OF_SLAVES-1:0]   pselx,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [3:0]                cfg_wait_states,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int DEPTH  = SLAVE_MEMORY_SIZE * 1024 / STRB_W;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] BASE   = ADDRESS_WIDTH'(SLAVE_ID * (SLAVE_MEMORY_SIZE + SLAVE_MEMORY_GAP) * 1024);
  localparam logic [ADDRESS_WIDTH-1:0] SIZE_B = ADDRESS_WIDTH'(SLAVE_MEMORY_SIZE * 1024);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic [IDX_W-1:0]       idx_q, idx_in, idx_cur;
  logic                   write_q, err_q, err_in, err_cur, write_cur;
  logic [DATA_WIDTH-1:0]  wdata_q, prdata_d;
  logic [STRB_W-1:0]      strb_q;
  logic                   sel, setup, done, wr_en, pready_d, pslverr_d;
  logic [ADDRESS_WIDTH:0] diff;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   unused_ok;

  assign sel       = pselx[SLAVE_ID];
  // The extra top bit of diff is the borrow, i.e. paddr below BASE.
  assign diff      = {1'b0, paddr} - {1'b0, BASE};
  assign idx_in    = diff[SHIFT +: IDX_W];
  assign err_in    = diff[ADDRESS_WIDTH] | (diff[ADDRESS_WIDTH-1:0] >= SIZE_B) | (paddr[1:0] != 2'b00) |
                     ((PRIV_ONLY != 0) & ~pprot[0]);
  // During setup the response is predicted from live inputs; later from the latched copy.
  assign idx_cur   = (state_q == IDLE) ? idx_in : idx_q;
  assign err_cur   = (state_q == IDLE) ? err_in : err_q;
  assign write_cur = (state_q == IDLE) ? pwrite : write_q;
  assign wr_en     = done & write_q & ~err_q;
  assign unused_ok = ^{pselx, pprot[2:1], diff};

  // Next state, wait counter, and the registered response for the following cycle
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    setup   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (sel && !penable) begin
        setup   = 1'b1;
        state_d = ACCESS;
        wcnt_d  = cfg_wait_states;
      end
      ACCESS: if (!sel) state_d = IDLE;
        else if (penable && wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
        else if (penable) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
    pready_d  = (state_d == ACCESS) && (wcnt_d == 4'd0);
    pslverr_d = pready_d & err_cur;
    prdata_d  = (pready_d && !err_cur && !write_cur) ? mem[idx_cur] : '0;
  end

  // Control state and registered outputs
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
    end

  // Transfer attributes captured in the setup cycle, and byte-strobed memory writes
  always_ff @(posedge pclk) begin
    if (setup) begin
      idx_q   <= idx_in;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      err_q   <= err_in;
    end
    if (wr_en)
      for (int i = 0; i < STRB_W; i++)
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule
